// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_seq_pkg : opcodes, FSM states and defaults for alu_seq          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_seq_muldiv : iterative shift-add multiplier / restoring divider |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RSTa,
  input  logic             load,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             last
);

  localparam int                 c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_run, r_div, r_qneg, r_rneg;
  logic [4:0]         r_op;
  logic [WIDTH-1:0]   r_hi, r_lo, r_m;

  logic               w_signed_a, w_signed_b, w_a_neg, w_b_neg, w_is_div, w_fit;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_hi_n, w_lo_n, w_diff, w_q, w_r;
  logic [WIDTH:0]     w_sum, w_shift;
  logic [2*WIDTH-1:0] w_prod;

  assign w_signed_b = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign w_signed_a = w_signed_b || (op == OP_MULHSU);
  assign w_a_neg    = w_signed_a && a[WIDTH-1];
  assign w_b_neg    = w_signed_b && b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -a : a;
  assign w_b_mag    = w_b_neg ? -b : b;
  assign w_is_div   = (op >= OP_DIV);

  // hi:lo is the product shifting right, or remainder:quotient shifting left
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_fit   = (w_shift >= {1'b0, r_m});
  assign w_diff  = w_shift[WIDTH-1:0] - r_m;

  always_comb begin
    if (r_div) begin
      w_hi_n = w_fit ? w_diff : w_shift[WIDTH-1:0];
      w_lo_n = {r_lo[WIDTH-2:0], w_fit};
    end else begin
      w_hi_n = w_sum[WIDTH:1];
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign w_prod = r_qneg ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
  assign w_q    = r_qneg ? -w_lo_n : w_lo_n;
  assign w_r    = r_rneg ? -w_hi_n : w_hi_n;

  always_comb begin
    result = '0;
    case (r_op)
      OP_MUL:                       result = w_prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = w_prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              result = w_q;
      OP_REM, OP_REMU:              result = w_r;
      default:                      result = '0;
    endcase
  end

  assign last = r_run && (r_cnt == '0);

  always_ff @(posedge CLK) begin
    if (RSTa) begin
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_div  <= 1'b0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_op   <= OP_ADD;
      r_hi   <= '0;
      r_lo   <= '0;
      r_m    <= '0;
    end else if (load) begin
      r_cnt  <= c_cnt_init;
      r_run  <= 1'b1;
      r_div  <= w_is_div;
      r_qneg <= w_a_neg ^ w_b_neg;
      r_rneg <= w_a_neg;
      r_op   <= op;
      r_hi   <= '0;
      r_lo   <= w_is_div ? w_a_mag : w_b_mag;
      r_m    <= w_is_div ? w_b_mag : w_a_mag;
    end else if (r_run) begin
      r_hi <= w_hi_n;
      r_lo <= w_lo_n;
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_seq : sequential RV32IM ALU with Start/Done handshake           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RSTa,
  input  logic             Start,
  input  logic [4:0]       ALU_operation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             Busy,
  output logic             Done
);

  localparam int               c_sh_w    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_res, w_alu, w_md_result;
  logic               r_zero, w_accept, w_is_md, w_div_op, w_div_spec, w_load, w_md_last;
  logic [c_sh_w-1:0]  w_shamt;

  assign w_shamt    = B[c_sh_w-1:0];
  assign w_accept   = Start && (r_state != CALC);
  assign w_is_md    = (ALU_operation >= OP_MUL) && (ALU_operation <= OP_REMU);
  assign w_div_op   = (ALU_operation >= OP_DIV) && (ALU_operation <= OP_REMU);
  assign w_div_spec = w_div_op && ((B == '0) ||
                      (((ALU_operation == OP_DIV) || (ALU_operation == OP_REM)) &&
                       (A == c_min_neg) && (B == '1)));
  assign w_load     = w_accept && w_is_md && !w_div_spec;

  // Divide rows only matter for the zero-divisor / overflow shortcuts
  always_comb begin
    w_alu = '0;
    case (ALU_operation)
      OP_ADD:          w_alu = A + B;
      OP_SUB:          w_alu = A - B;
      OP_AND:          w_alu = A & B;
      OP_OR:           w_alu = A | B;
      OP_XOR:          w_alu = A ^ B;
      OP_SLL:          w_alu = A << w_shamt;
      OP_SRL:          w_alu = A >> w_shamt;
      OP_SRA:          w_alu = $signed(A) >>> w_shamt;
      OP_SLT:          w_alu = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU:         w_alu = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_DIV, OP_DIVU: w_alu = (B == '0) ? '1 : A;
      OP_REM, OP_REMU: w_alu = (B == '0) ? A : '0;
      default:         w_alu = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) w_state_nxt = w_load ? CALC : DONE;
        else          w_state_nxt = IDLE;
      end
      CALC:    if (w_md_last) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RSTa) begin
      r_state <= IDLE;
      r_res   <= '0;
      r_zero  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && !w_load) begin
        r_res  <= w_alu;
        r_zero <= (w_alu == '0);
      end else if ((r_state == CALC) && w_md_last) begin
        r_res  <= w_md_result;
        r_zero <= (w_md_result == '0);
      end
    end
  end

  alu_seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .CLK    (CLK),
    .RSTa   (RSTa),
    .load   (w_load),
    .op     (ALU_operation),
    .a      (A),
    .b      (B),
    .result (w_md_result),
    .last   (w_md_last)
  );

  assign res  = r_res;
  assign zero = r_zero;
  assign Busy = (r_state == CALC);
  assign Done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_seq : directed vectors for alu_seq at WIDTH 32 and 16         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, start16;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic [31:0] res32;
  logic [15:0] res16;
  logic        zero32, zero16, busy32, busy16, done32, done16;
  bit          sel16;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) u_dut32 (
    .CLK(clk), .RSTa(rst), .Start(start32), .ALU_operation(op), .A(a), .B(b),
    .res(res32), .zero(zero32), .Busy(busy32), .Done(done32)
  );

  alu_seq #(.WIDTH(16)) u_dut16 (
    .CLK(clk), .RSTa(rst), .Start(start16), .ALU_operation(op), .A(a[15:0]), .B(b[15:0]),
    .res(res16), .zero(zero16), .Busy(busy16), .Done(done16)
  );

  function automatic logic [31:0] cur_res();
    return sel16 ? {16'h0, res16} : res32;
  endfunction
  function automatic logic cur_zero();
    return sel16 ? zero16 : zero32;
  endfunction
  function automatic logic cur_busy();
    return sel16 ? busy16 : busy32;
  endfunction
  function automatic logic cur_done();
    return sel16 ? done16 : done32;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel16) start16 = v;
    else       start32 = v;
  endtask

  // Counts negedges until Done; a missing Done shows up as a latency of 200
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (cur_done()) break;
      if (cur_busy()) bc++;
    end
  endtask

  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y;
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    a  = $urandom;
    b  = $urandom;
    op = 5'($urandom_range(0, 31));
  endtask

  task automatic run(input string tag, input bit w16, input logic [4:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int exp_lat);
    int lat, bc;
    sel16 = w16;
    issue(o, x, y);
    wait_done(lat, bc);
    check({tag, "_lat"},  64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(bc), 64'(exp_lat - 1));
    check({tag, "_res"},  64'(cur_res()), 64'(exp));
    check({tag, "_zero"}, 64'(cur_zero()), 64'(exp == 32'h0));
    @(negedge clk);
    check({tag, "_pulse"}, 64'(cur_done()), 64'h0);
  endtask

  initial begin
    int lat, bc;
    rst = 1'b1; start32 = 1'b0; start16 = 1'b0; op = '0; a = '0; b = '0; sel16 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_res32",  64'(res32),  64'h0);
    check("rst_zero32", 64'(zero32), 64'h1);
    check("rst_busy32", 64'(busy32), 64'h0);
    check("rst_done32", 64'(done32), 64'h0);
    check("rst_res16",  64'(res16),  64'h0);
    check("rst_zero16", 64'(zero16), 64'h1);

    run("add_ovf",  0, OP_ADD,  32'h7FFF_FFFF, 32'h1,  32'h8000_0000, 1);
    run("sub_zero", 0, OP_SUB,  32'd5,         32'd5,  32'h0,         1);
    run("sra",      0, OP_SRA,  32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    run("slt",      0, OP_SLT,  32'hFFFF_FFFF, 32'h1,  32'h1,         1);
    run("sltu",     0, OP_SLTU, 32'hFFFF_FFFF, 32'h1,  32'h0,         1);
    run("xor",      0, OP_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1);
    run("badop",    0, 5'd20,   32'h1234,      32'h1,  32'h0,         1);
    run("mulh",     0, OP_MULH, 32'hFFFF_FFFE, 32'd3,  32'hFFFF_FFFF, 33);
    run("mulhu",    0, OP_MULHU, 32'hFFFF_FFFE, 32'd3, 32'h2,         33);
    run("mulhsu",   0, OP_MULHSU, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33);
    run("mul_neg",  0, OP_MUL,  32'hFFFF_FFFD, 32'd5,  32'hFFFF_FFF1, 33);
    run("div",      0, OP_DIV,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFD, 33);
    run("rem",      0, OP_REM,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 33);
    run("divu",     0, OP_DIVU, 32'd100,       32'd7,  32'd14,        33);
    run("divu_z",   0, OP_DIVU, 32'd7,         32'd0,  32'hFFFF_FFFF, 1);
    run("remu_z",   0, OP_REMU, 32'd7,         32'd0,  32'd7,         1);
    run("div_ovf",  0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",  0, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,  1);

    // Start while busy must be dropped
    sel16 = 1'b0;
    issue(OP_MUL, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    op = OP_ADD; a = 32'd100; b = 32'd100; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    wait_done(lat, bc);
    check("ign_lat", 64'(lat + 6), 64'd33);
    check("ign_res", 64'(res32), 64'd42);

    // Back-to-back: ADD, MUL issued in ADD's Done cycle, SUB in MUL's Done cycle
    @(negedge clk);
    op = OP_ADD; a = 32'd2; b = 32'd3; start32 = 1'b1;
    @(posedge clk);
    #1;
    op = OP_MUL; a = 32'd6; b = 32'd7;
    @(negedge clk);
    check("b2b_done1", 64'(done32), 64'h1);
    check("b2b_res1",  64'(res32),  64'd5);
    @(posedge clk);
    #1;
    start32 = 1'b0;
    wait_done(lat, bc);
    check("b2b_lat2", 64'(lat), 64'd33);
    check("b2b_res2", 64'(res32), 64'd42);
    op = OP_SUB; a = 32'd9; b = 32'd4; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    @(negedge clk);
    check("b2b_done3", 64'(done32), 64'h1);
    check("b2b_res3",  64'(res32),  64'd5);
    @(negedge clk);
    check("b2b_pulse", 64'(done32), 64'h0);

    // Reset in the middle of an iterative op
    issue(OP_MUL, 32'd6, 32'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy32), 64'h0);
    check("abort_done", 64'(done32), 64'h0);
    check("abort_res",  64'(res32),  64'h0);
    check("abort_zero", 64'(zero32), 64'h1);
    rst = 1'b0;
    run("mul_after", 0, OP_MUL, 32'd6, 32'd7, 32'd42, 33);

    run("w16_mulh",  1, OP_MULH,  32'hFFFE, 32'd3, 32'hFFFF, 17);
    run("w16_mulhu", 1, OP_MULHU, 32'hFFFE, 32'd3, 32'h2,    17);
    run("w16_mul",   1, OP_MUL,   32'd6,    32'd7, 32'd42,   17);
    run("w16_div",   1, OP_DIV,   32'hFFF9, 32'd2, 32'hFFFD, 17);
    run("w16_rem",   1, OP_REM,   32'hFFF9, 32'd2, 32'hFFFF, 17);
    run("w16_divuz", 1, OP_DIVU,  32'd7,    32'd0, 32'hFFFF, 1);
    run("w16_remuz", 1, OP_REMU,  32'd7,    32'd0, 32'd7,    1);
    run("w16_dovf",  1, OP_DIV,   32'h8000, 32'hFFFF, 32'h8000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the RISC-V datapath: executes the RV32I integer operations in one cycle and the RV32M multiply/divide/remainder operations iteratively, behind a Start/Done handshake. It replaces the purely combinational ALU in the execute stage. The pipeline controller stalls on Busy while a multi-cycle operation runs.

## Interface
- WIDTH, 32: operand and result width in bits (≥ 8, even).
- CLK  in  1  system clock; all state updates on rising edge.
- RSTa  in  1  reset, synchronous, active-high.
- Start  in  1  request; sampled on a rising edge only when Busy=0.
- ALU_operation  in  5  operation code (enum in package, below).
- A  in  WIDTH  operand 1 (rs1), captured on an accepted Start.
- B  in  WIDTH  operand 2 (rs2/imm), captured on an accepted Start.
- res  out  WIDTH  registered result; held until the next Done.
- zero  out  1  registered; 1 when res == 0, updated together with res.
- Busy  out  1  iterative operation in progress.
- Done  out  1  one-cycle pulse: res/zero valid from this cycle onward.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU. Codes 18–31 give res=0, zero=1, latency 1.
- Shifts use B[log2(WIDTH)-1:0]; SLT/SLTU return 0 or 1.
- ADD/SUB wrap modulo 2^WIDTH; no flags other than zero.
- MUL returns the low WIDTH bits. MULH, MULHSU and MULHU return the high WIDTH bits of the 2·WIDTH product (signed×signed, signed×unsigned, unsigned×unsigned).
- Multiply is radix-2 shift-add over magnitudes, with the sign fixed at the end. Divide is restoring, over magnitudes. DIV/REM round toward zero; the remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones, remainder = A. No iteration.
- Signed overflow (A = most-negative, B = −1, DIV/REM): quotient = A, remainder = 0. No iteration.
- FSM states:
  - IDLE: accept Start. Single-cycle op or a divide special case goes to DONE. MUL*/DIV*/REM* go to CALC, loading counter = WIDTH−1.
  - CALC: one iteration per cycle; counter decrements; at 0 go to DONE.
  - DONE: Done=1 for this cycle. Start is accepted here exactly as in IDLE (back-to-back issue). Otherwise go to IDLE.
- Busy = (state == CALC). Start while Busy is ignored, with no queueing.
- A, B and ALU_operation may change freely after acceptance; the captured copies are used.

## Timing
- Reset values: res = 0, zero = 1, Busy = 0, Done = 0, state = IDLE, counter = 0.
- RSTa asserted during CALC aborts the operation. The partial result is discarded and the reset values apply from the next edge.
- Latency is counted from the edge that accepts Start to the edge after which Done = 1.
  - Single-cycle ops and divide special cases: 1.
  - MUL*/DIV*/REM*: WIDTH + 1, with Busy high for exactly WIDTH cycles.
- Back-to-back issue: Start asserted in the DONE cycle yields Done again 1 or WIDTH+1 cycles later. Done never stays high two cycles for a single request.
- res/zero change only on the edge that raises Done (or on reset).

## Structure
- Package alu_seq_pkg holds:
  - the alu_op_t enum (5 bits, codes above);
  - the state_t enum {IDLE, CALC, DONE};
  - the DEFAULT_WIDTH = 32 constant.
- Sub-module alu_seq_muldiv: the iterative engine (operand magnitude/sign capture, accumulator/remainder registers, iteration counter, final sign fix).
  - Its ports: CLK, RSTa, load, op, a, b, result, last.
  - The top level holds the combinational single-cycle unit, the FSM and the output registers.

## Test plan
- ADD 0x7FFFFFFF + 1 → res = 0x80000000, zero = 0, Done one cycle after Start. SUB 5 − 5 → res = 0, zero = 1.
- SRA 0x80000000 by B = 0x24 (shift by 4) → 0xF8000000. SLT(−1, 1) → 1. SLTU(−1, 1) → 0.
- MULH 0xFFFFFFFE × 3 → 0xFFFFFFFF; MULHU same operands → 2. Busy high 32 cycles, Done at latency 33.
- DIV −7 / 2 → −3; REM → −1. DIVU 7 / 0 → 0xFFFFFFFF and REMU 7 / 0 → 7, both with latency 1. DIV 0x80000000 / −1 → 0x80000000.
- Start pulsed during CALC with different operands → ignored; the first result is returned unchanged. Start in the DONE cycle → the second Done arrives at the correct latency.
- RSTa asserted mid-CALC → next cycle Busy = 0, Done = 0, res = 0, zero = 1. A fresh MUL 6 × 7 afterwards → 42.
- Repeat the MUL/DIV cases with WIDTH = 16.
